// File: rtl/branch_ctrl_pkg.sv
// Shared types and defaults for the branch sequencer: FSM state, jump-kind
// encoding with its priority encoder, and default parameter values.
package branch_ctrl_pkg;

  localparam int BC_ADDR_W   = 32;
  localparam int BC_FLAG_LAT = 2;
  localparam int BC_CNT_W    = 16;

  typedef enum logic {
    BC_RUN,
    BC_HOLD
  } bc_state_t;

  typedef enum logic [1:0] {
    JK_NONE,
    JK_I,
    JK_CI,
    JK_CD
  } jump_kind_t;

  // Unconditional beats jump-if-zero, which beats jump-if-not-zero.
  function automatic jump_kind_t jump_encode(input logic valid,
                                             input logic jump_i,
                                             input logic jump_ci,
                                             input logic jump_cd);
    if (!valid)       return JK_NONE;
    else if (jump_i)  return JK_I;
    else if (jump_ci) return JK_CI;
    else if (jump_cd) return JK_CD;
    else              return JK_NONE;
  endfunction

endpackage

// File: rtl/branch_ctrl_unit_flag_scoreboard.sv
// In-flight FlagZ writer tracker: one bit per edge between a writer entering
// EX and its result reaching flag_z. `clear` is a synchronous clear.
module flag_scoreboard
  import branch_ctrl_pkg::*;
#(
  parameter int FLAG_LAT = BC_FLAG_LAT
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                shift_en,
  input  logic                set_flag,
  output logic [FLAG_LAT-1:0] pending
);

  logic [FLAG_LAT-1:0] r_pend;

  generate
    if (FLAG_LAT == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (clear)         r_pend <= '0;
        else if (shift_en) r_pend <= set_flag;
      end
    end else begin : g_shift
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, whatever order the blocks evaluate in.
      always_ff @(posedge clk) begin
        if (clear)         r_pend <= '0;
        else if (shift_en) r_pend <= {r_pend[FLAG_LAT-2:0], set_flag};
      end
    end
  endgenerate

  assign pending = r_pend;

endmodule

// File: rtl/branch_ctrl_unit.sv
// Branch sequencer beside ID: resolves JumpI/JumpCI/JumpCD against FlagZ and
// stalls conditional jumps behind in-flight flag writers.
// Optional statistics counters are enabled by defining BRANCH_CTRL_STATS_EN.
module branch_ctrl_unit
  import branch_ctrl_pkg::*;
#(
  parameter int ADDR_W   = BC_ADDR_W,
  parameter int FLAG_LAT = BC_FLAG_LAT,
  parameter int CNT_W    = BC_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_jump_i,
  input  logic              id_jump_ci,
  input  logic              id_jump_cd,
  input  logic              id_sets_flag,
  input  logic [ADDR_W-1:0] id_target,
  input  logic              flag_z,
  input  logic              ext_stall,
  output logic              pc_src,
  output logic [ADDR_W-1:0] pc_target,
  output logic              stall_front,
  output logic              flush_if_id,
  output logic              flush_id_ex,
`ifdef BRANCH_CTRL_STATS_EN
  output logic [CNT_W-1:0]  stat_taken,
  output logic [CNT_W-1:0]  stat_not_taken,
  output logic [CNT_W-1:0]  stat_stall_cyc,
`endif
  output logic              ctrl_busy
);

  generate
    if (FLAG_LAT < 1 || ADDR_W < 1 || CNT_W < 1) begin : g_bad_param
      $error("branch_ctrl_unit: FLAG_LAT, ADDR_W and CNT_W must all be >= 1");
    end
  endgenerate

  bc_state_t           r_state;
  jump_kind_t          w_kind;
  logic [FLAG_LAT-1:0] w_pending;
  logic                w_pend_any;
  logic                w_cond;
  logic                w_taken;
  logic                w_wait;
  logic                w_active;
  logic                w_resolve;
  logic                w_set_flag;

  assign w_kind     = jump_encode(id_valid, id_jump_i, id_jump_ci, id_jump_cd);
  assign w_cond     = (w_kind == JK_CI) || (w_kind == JK_CD);
  assign w_taken    = (w_kind == JK_I) ||
                      ((w_kind == JK_CI) &&  flag_z) ||
                      ((w_kind == JK_CD) && !flag_z);
  assign w_pend_any = |w_pending;
  // HOLD keeps waiting on pend alone; ID is frozen so the jump is still there.
  assign w_wait     = w_pend_any && (r_state == BC_HOLD || w_cond);
  assign w_active   = !rst && !ext_stall;
  assign w_resolve  = w_active && !w_wait && (w_kind != JK_NONE);

  // NOTE: every output gets a default before the conditions so no path
  // leaves a signal unassigned, which would infer a latch.
  always_comb begin
    pc_src      = 1'b0;
    pc_target   = '0;
    stall_front = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (w_active) begin
      if (w_wait) begin
        stall_front = 1'b1;
        flush_id_ex = 1'b1;
      end else if (w_taken) begin
        pc_src      = 1'b1;
        pc_target   = id_target;
        flush_if_id = 1'b1;
      end
    end
  end

  assign ctrl_busy  = (r_state == BC_HOLD);
  // A writer only counts once it actually advances into EX.
  assign w_set_flag = !stall_front && !flush_id_ex && id_valid && id_sets_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BC_RUN;
    end else if (!ext_stall) begin
      case (r_state)
        BC_RUN:  if (w_wait)  r_state <= BC_HOLD;
        BC_HOLD: if (!w_wait) r_state <= BC_RUN;
        default: r_state <= BC_RUN;
      endcase
    end
  end

  flag_scoreboard #(
    .FLAG_LAT (FLAG_LAT)
  ) u_flag_scoreboard (
    .clk      (clk),
    .clear    (rst),
    .shift_en (!ext_stall),
    .set_flag (w_set_flag),
    .pending  (w_pending)
  );

`ifdef BRANCH_CTRL_STATS_EN
  logic [CNT_W-1:0] r_taken;
  logic [CNT_W-1:0] r_not_taken;
  logic [CNT_W-1:0] r_stall_cyc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_taken     <= '0;
      r_not_taken <= '0;
      r_stall_cyc <= '0;
    end else if (!ext_stall) begin
      if (w_resolve &&  w_taken) r_taken     <= r_taken + CNT_W'(1);
      if (w_resolve && !w_taken) r_not_taken <= r_not_taken + CNT_W'(1);
      if (stall_front)           r_stall_cyc <= r_stall_cyc + CNT_W'(1);
    end
  end

  assign stat_taken     = r_taken;
  assign stat_not_taken = r_not_taken;
  assign stat_stall_cyc = r_stall_cyc;
`endif

endmodule
